// File: rtl/tx_ffe_driver.sv
// 3-tap FFE de-emphasis driver: requests one bit per UI, holds the equalized level for N clocks.
// Optional build macro TX_FFE_SATURATE_EN clamps the tap sum instead of wrapping it to OUT_W.
module tx_ffe_driver #(
    parameter int N      = 10,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8,
    parameter logic signed [COEF_W-1:0] C_PRE  = COEF_W'(-8),
    parameter logic signed [COEF_W-1:0] C_MAIN = COEF_W'(96),
    parameter logic signed [COEF_W-1:0] C_POST = COEF_W'(-24)
) (
    input  logic                    Sample_CLK,
    input  logic                    Rst,
    input  logic                    Data_in,
    input  logic                    Data_valid,
    output logic                    Data_req,
    output logic signed [OUT_W-1:0] Data_out,
    output logic                    Underflow,
    output logic                    Active
);
    localparam int CW = $clog2(N);
    localparam int SW = COEF_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           rst_q;
    logic [1:0]     drain;
    // Slot encoding: {nonzero, positive}; 2'b00 is the idle (0) symbol.
    logic [1:0]     s_next, s_cur, s_prev, sym_in;
    logic           accept;
    logic signed [SW-1:0]    level;
    logic signed [OUT_W-1:0] level_red;

    function automatic logic signed [SW-1:0] tap(input logic [1:0] s,
                                                 input logic signed [COEF_W-1:0] c);
        logic signed [SW-1:0] e;
        e = {{2{c[COEF_W-1]}}, c};
        if (!s[1])    return '0;
        else if (s[0]) return e;
        else          return -e;
    endfunction

    // The counter sits at 0 through reset and the first edge after release.
    always_comb begin
        if (rst_q || cnt == CW'(N - 1)) cnt_nxt = '0;
        else                            cnt_nxt = cnt + CW'(1);
    end

    assign accept = Data_req & Data_valid;
    assign sym_in = accept ? {1'b1, Data_in} : 2'b00;
    assign level  = tap(sym_in, C_PRE) + tap(s_next, C_MAIN) + tap(s_cur, C_POST);

`ifdef TX_FFE_SATURATE_EN
    localparam logic signed [SW-1:0] OMAX = SW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SW-1:0] OMIN = ~OMAX;
    always_comb begin
        if (level > OMAX)      level_red = OMAX[OUT_W-1:0];
        else if (level < OMIN) level_red = OMIN[OUT_W-1:0];
        else                   level_red = level[OUT_W-1:0];
    end
`else
    assign level_red = level[OUT_W-1:0];
`endif

    always_ff @(posedge Sample_CLK) begin
        if (Rst) begin
            rst_q     <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
            drain     <= '0;
            s_next    <= '0;
            s_cur     <= '0;
            s_prev    <= '0;
            Data_req  <= 1'b0;
            Data_out  <= '0;
            Underflow <= 1'b0;
            Active    <= 1'b0;
        end else begin
            rst_q     <= 1'b0;
            cnt       <= cnt_nxt;
            Data_req  <= (cnt_nxt == CW'(N - 1));
            Underflow <= 1'b0;
            if (Data_req) begin
                // In IDLE without a bit every slot is already 0, so the shift is a no-op.
                s_prev   <= s_cur;
                s_cur    <= s_next;
                s_next   <= sym_in;
                Data_out <= level_red;
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state  <= RUN;
                            Active <= 1'b1;
                            drain  <= '0;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            drain <= '0;
                        end else if (drain == 2'd2) begin
                            state  <= IDLE;
                            Active <= 1'b0;
                            drain  <= '0;
                        end else begin
                            drain     <= drain + 2'd1;
                            Underflow <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tx_ffe_driver.sv
// Bench for tx_ffe_driver: directed literal checks plus random streams against a symbol-level model.
module tb_tx_ffe_driver;
    localparam int N = 10;
    localparam int CP = -8, CM = 96, CQ = -24;

    logic clk = 0, Rst = 1, Data_in = 0, Data_valid = 0;
    logic Data_req, Underflow, Active;
    logic signed [7:0] Data_out;

    int checks = 0, failures = 0;

    tx_ffe_driver dut (
        .Sample_CLK(clk), .Rst(Rst), .Data_in(Data_in), .Data_valid(Data_valid),
        .Data_req(Data_req), .Data_out(Data_out), .Underflow(Underflow), .Active(Active)
    );

    always #5 clk = ~clk;

    function automatic int red(input int v);
`ifdef TX_FFE_SATURATE_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
`else
        return (((v + 128) % 256) + 256) % 256 - 128;
`endif
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: edges since release give request timing; symbol history gives everything else.
    int  t = 0;
    int  s[3];
    bit  m_req = 0, m_uf = 0, m_act = 0, ready = 0;
    int  m_out = 0;
    always @(posedge clk) begin
        if (Rst) begin
            t = 0; m_req = 0; m_uf = 0; m_act = 0; m_out = 0; ready = 1;
            s[0] = 0; s[1] = 0; s[2] = 0;
        end else begin
            bit acc, was;
            acc  = m_req && Data_valid;
            was  = m_act;
            m_uf = 0;
            if (m_req) begin
                s[2] = s[1]; s[1] = s[0];
                s[0] = acc ? (Data_in ? 1 : -1) : 0;
                m_act = (s[0] != 0) || (s[1] != 0) || (s[2] != 0);
                m_uf  = was && !acc && m_act;
                m_out = red(CP * s[0] + CM * s[1] + CQ * s[2]);
            end
            t++;
            m_req = (t % N == 0);
        end
    end

    always @(negedge clk) begin
        if (ready) begin
            chk("req", Data_req, m_req);
            chk("out", int'(Data_out), m_out);
            chk("uf", Underflow, m_uf);
            chk("active", Active, m_act);
        end
    end

    // Drive one UI worth of input, return at the negedge just after the next boundary.
    task automatic send(input logic v, input logic d);
        int k;
        Data_valid = v; Data_in = d; k = 0;
        @(negedge clk);
        while (!Data_req && k < 4 * N) begin @(negedge clk); k++; end
        if (k >= 4 * N) chk("req_timeout", k, 0);
        else begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic req_delay(input string name);
        int k;
        k = 0;
        while (!Data_req && k < 4 * N) begin @(negedge clk); k++; end
        chk(name, k, N);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out", int'(Data_out), 0);
        chk("rst_req", Data_req, 0);
        chk("rst_act", Active, 0);
        Rst = 0;
        req_delay("first_req");
        send(0, 0); send(0, 0);
        chk("idle_out", int'(Data_out), 0);

        // Isolated 1
        send(1, 1); chk("iso_pre", int'(Data_out), -8); chk("iso_act", Active, 1);
        send(0, 0); chk("iso_main", int'(Data_out), 96); chk("iso_uf1", Underflow, 1);
        send(0, 0); chk("iso_post", int'(Data_out), -24); chk("iso_uf2", Underflow, 1);
        send(0, 0); chk("iso_end", int'(Data_out), 0); chk("iso_uf3", Underflow, 0);
        chk("iso_idle", Active, 0);

        // Steady streams and alternating pattern
        repeat (4) send(1, 1);
        chk("ones", int'(Data_out), 64);
        repeat (4) send(1, 0);
        chk("zeros", int'(Data_out), -64);
        send(1, 1); chk("alt_a", int'(Data_out), -80);
        send(1, 0);
`ifdef TX_FFE_SATURATE_EN
        chk("alt_pos", int'(Data_out), 127);
`else
        chk("alt_pos", int'(Data_out), -128);
`endif
        send(1, 1); chk("alt_neg", int'(Data_out), -128);

        // Gap of one request
        send(0, 0); chk("gap_uf", Underflow, 1); chk("gap_act", Active, 1);
        send(1, 1); chk("gap_resume_uf", Underflow, 0); chk("gap_resume_act", Active, 1);

        // Reset at counter=4 during a stream
        send(1, 0);
        repeat (4) @(negedge clk);
        Rst = 1;
        @(negedge clk);
        chk("mid_rst_out", int'(Data_out), 0);
        chk("mid_rst_act", Active, 0);
        Rst = 0;
        req_delay("post_rst_req");

        // Random streams with occasional long gaps and resets
        for (int i = 0; i < 200; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                repeat ($urandom_range(1, N)) @(negedge clk);
                Rst = 1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                Rst = 0;
            end else if (r < 15) begin
                repeat ($urandom_range(1, 4)) send(0, 0);
            end else begin
                send(logic'($urandom_range(0, 5) != 0), logic'($urandom_range(0, 1)));
            end
        end
        Data_valid = 0;
        repeat (4) send(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_ffe_driver.md
# tx_ffe_driver

Transmit-side 3-tap feed-forward equalizer (de-emphasis driver) that sits in front of the channel model in the SerDes link bench. It requests one serial bit per unit interval (UI) through a valid/request handshake and converts the bit stream into a signed fixed-point drive level. Each level is held for N `Sample_CLK` cycles, so the channel model, running on the same oversampled clock, sees pre-compensated symbols. It also tracks idle and underflow conditions so the link can start and stop cleanly.

## Interface
- `N`, 10: `Sample_CLK` cycles per UI (oversampling ratio); legal range 2..256.
- `COEF_W`, 8: width of the signed tap coefficients.
- `OUT_W`, 8: width of the signed output level.
- `C_PRE`, -8: pre-cursor tap, signed.
- `C_MAIN`, 96: main-cursor tap, signed.
- `C_POST`, -24: post-cursor tap, signed.

- `Sample_CLK` input 1: the only clock, oversampled at N per UI.
- `Rst` input 1: synchronous, active-high reset.
- `Data_in` input 1: serial bit offered by the source.
- `Data_valid` input 1: `Data_in` is valid.
- `Data_req` output 1: the driver accepts a bit this cycle.
- `Data_out` output OUT_W: signed drive level, two's complement.
- `Underflow` output 1: one-cycle pulse when a UI boundary passes with no bit accepted while in RUN.
- `Active` output 1: high in RUN state.

## Operation
- **Symbol mapping.** Each pipeline slot holds a symbol value {+1, -1, 0}.
  - bit 1 maps to +1.
  - bit 0 maps to -1.
  - an empty (idle) slot maps to 0.
- **Pipeline.** Three slots: `s_next` (pre-cursor), `s_cur` (main), `s_prev` (post).
  - On each UI boundary the slots shift: `s_prev`←`s_cur`, `s_cur`←`s_next`, `s_next`←new symbol.
  - The new symbol is the accepted bit, or 0 if no bit was accepted.
- **Level equation.** `Data_out` = C_PRE·`s_next` + C_MAIN·`s_cur` + C_POST·`s_prev`.
  - The sum is computed at width COEF_W+2, sign-extended.
  - It is then reduced to OUT_W as described under Configuration.
- **Handshake.**
  - A bit is accepted when `Data_req` and `Data_valid` are both high on the same `Sample_CLK` edge.
  - `Data_valid` is ignored in every other cycle; there is no back-pressure on the source.
- **States.**
  - IDLE: all slots are 0 and `Data_out`=0. An accepted bit moves the block to RUN.
  - RUN: a UI boundary with no accepted bit inserts a 0 symbol and pulses `Underflow`. Three consecutive boundaries without an accepted bit (pipeline drained to all 0) return the block to IDLE; no `Underflow` pulse is issued on that third boundary.
  - A valid bit arriving in IDLE does not pulse `Underflow`.
- **Reset values.**
  - UI counter = 0, state IDLE, all slots 0.
  - `Data_out`=0, `Data_req`=0, `Underflow`=0, `Active`=0.
  - Reset asserted mid-UI or mid-stream discards the pipeline immediately. The counter restarts from 0 on the first edge after `Rst` falls.

## Timing
- **UI counter.** Counts 0..N-1 and wraps on `Sample_CLK`.
- **Request timing.** `Data_req` is a registered output, high exactly in the cycles where the counter equals N-1.
  - The first request appears N cycles after reset release.
  - Requests then repeat every N cycles.
- **UI boundary.** This is the edge on which `Data_req` is high. On that edge:
  - the shift happens;
  - `Data_out` is registered from the post-shift slots;
  - state, `Active` and `Underflow` are all updated.
- **Hold.** `Data_out` is held constant for exactly N cycles.
- **Latency.**
  - A bit accepted at boundary k first affects `Data_out` as pre-cursor at boundary k.
  - It acts as main cursor at boundary k+1, N cycles later.
  - It acts as post-cursor at boundary k+2.
- **Underflow pulse.** `Underflow` is high for the single cycle following the affected boundary edge.

## Configuration
- **Macro:** `TX_FFE_SATURATE_EN`.
- **Defined:** the COEF_W+2 sum is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. With the defaults, +128 becomes 127.
- **Undefined:** the sum is truncated to its OUT_W LSBs (wrap-around). With the defaults, +128 becomes -128. No other behaviour changes.

## Test plan
- **Reset, then idle:** `Rst` high 3 cycles, `Data_valid`=0 → `Data_out`=0, `Active`=0, `Underflow` never set, `Data_req` pulses every 10 cycles starting at cycle 10.
- **Isolated 1:** single accepted bit 1, then no valid → `Data_out` sequence -8, 96, -24, 0. Each value held 10 cycles. `Underflow` pulses at the first and second following boundaries. `Active` drops at the third boundary.
- **Steady stream 1,1,1,1** → steady `Data_out` = -8+96-24 = 64. Bits 0,0,0,0 → -64.
- **Alternating 1,0,1,0 mid-stream** → `Data_out` at main=1 = (+8)+96+24 = 128. This reads 127 with `TX_FFE_SATURATE_EN` and -128 without it. At main=0 it is -128 in both builds.
- **Gap in stream:** `Data_valid` dropped for one request in RUN → one 0 symbol inserted, one `Underflow` pulse, `Active` stays 1, stream resumes on the next accepted bit.
- **Reset mid-UI:** `Rst` asserted at counter=4 during a stream → next edge `Data_out`=0, state IDLE. The first post-reset `Data_req` comes 10 cycles after `Rst` falls.
